// File: rtl/battleship_pkg.sv
// battleship_pkg
// Shared definitions for the battleship game blocks.
//   - game_status encodings driven to the display / LED logic
//   - map geometry (5 columns x 7 rows = 35 cells)
//   - coordinate helpers: cell-to-map-bit mapping and validity check
//   - scoreboard FSM state encoding
package battleship_pkg;

    localparam int MAP_BITS = 35;
    localparam int COLS     = 5;
    localparam int ROWS     = 7;

    typedef enum logic [1:0] {
        GS_IDLE    = 2'b00,
        GS_PLAYING = 2'b01,
        GS_WON     = 2'b10,
        GS_LOST    = 2'b11
    } game_status_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_PLAY,
        ST_RESULT,
        ST_WON,
        ST_LOST
    } sb_state_e;

    // Column 0 occupies the top seven map bits (28..34), column 4 the bottom seven.
    function automatic logic [5:0] coord_to_bit(input logic [2:0] x, input logic [2:0] y);
        int idx;
        idx = 28 - 7 * int'(x) + int'(y);
        return idx[5:0];
    endfunction

    function automatic logic coord_valid(input logic [2:0] x, input logic [2:0] y);
        return (int'(x) < COLS) && (int'(y) < ROWS);
    endfunction

endpackage

// File: rtl/attack_scoreboard_if.sv
// attack_scoreboard_if
// Bundles the attack-path inputs and the scoreboard results.
//   master : drives enable_attack, attack_pulse, x/y coordinate codes, map;
//            observes the counters, result and game status
//   slave  : the scoreboard itself (mirror directions)
interface attack_scoreboard_if;
    logic        enable_attack;
    logic        attack_pulse;
    logic [2:0]  x_coord_code;
    logic [2:0]  y_coord_code;
    logic [34:0] map;
    logic [3:0]  hit_count;
    logic [3:0]  shots_left;
    logic [3:0]  ship_count;
    logic        result_valid;
    logic        result_hit;
    logic        shot_rejected;
    logic [1:0]  game_status;

    modport master (
        output enable_attack, attack_pulse, x_coord_code, y_coord_code, map,
        input  hit_count, shots_left, ship_count, result_valid, result_hit,
               shot_rejected, game_status
    );

    modport slave (
        input  enable_attack, attack_pulse, x_coord_code, y_coord_code, map,
        output hit_count, shots_left, ship_count, result_valid, result_hit,
               shot_rejected, game_status
    );
endinterface

// File: rtl/result_hold_timer.sv
// result_hold_timer
// Loadable down-counter that stops at zero.
//   clk        in   clock
//   rst        in   synchronous active-high reset (count cleared to 0)
//   load_i     in   load load_val_i this cycle (has priority over counting)
//   load_val_i in   value loaded on load_i
//   done_o     out  high while the count is zero
module result_hold_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);
endmodule

// File: rtl/attack_scoreboard.sv
// attack_scoreboard
// Game referee behind the attack-confirm path: latches the ship map, counts
// ship cells, tracks shot history, hit and shot counters, holds each shot
// result for RESULT_CYCLES clocks and declares win/lose.
//   clk    in  divided system clock
//   reset  in  synchronous active-high reset
//   sb     slave modport of attack_scoreboard_if (attack inputs, results)
module attack_scoreboard #(
    parameter int MAX_SHOTS     = 15,
    parameter int RESULT_CYCLES = 3000,
    parameter int RES_W         = 12
) (
    input  logic                clk,
    input  logic                reset,
    attack_scoreboard_if.slave  sb
);
    import battleship_pkg::*;

    sb_state_e             state_q, state_d;
    logic [MAP_BITS-1:0]   map_q, map_d;
    logic [MAP_BITS-1:0]   hist_q, hist_d;
    logic [5:0]            idx_q, idx_d;
    logic [3:0]            ship_q, ship_d;
    logic [3:0]            hit_q, hit_d;
    logic [3:0]            shots_q, shots_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rhit_q, rhit_d;
    logic                  rej_q, rej_d;
    logic                  tmr_load;
    logic                  tmr_done;
    logic [5:0]            shot_bit;
    logic                  shot_ok;
    game_status_e          status;

    result_hold_timer #(.W(RES_W)) u_hold (
        .clk        (clk),
        .rst        (reset),
        .load_i     (tmr_load),
        .load_val_i (RES_W'(RESULT_CYCLES - 1)),
        .done_o     (tmr_done)
    );

    // Dropping enable_attack is a full game abort, same as reset.
    always_ff @(posedge clk) begin
        if (reset || !sb.enable_attack) begin
            state_q  <= ST_IDLE;
            hist_q   <= '0;
            idx_q    <= '0;
            ship_q   <= '0;
            hit_q    <= '0;
            shots_q  <= 4'(MAX_SHOTS);
            rvalid_q <= 1'b0;
            rhit_q   <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            map_q    <= map_d;
            hist_q   <= hist_d;
            idx_q    <= idx_d;
            ship_q   <= ship_d;
            hit_q    <= hit_d;
            shots_q  <= shots_d;
            rvalid_q <= rvalid_d;
            rhit_q   <= rhit_d;
            rej_q    <= rej_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        map_d    = map_q;
        hist_d   = hist_q;
        idx_d    = idx_q;
        ship_d   = ship_q;
        hit_d    = hit_q;
        shots_d  = shots_q;
        rvalid_d = rvalid_q;
        rhit_d   = rhit_q;
        rej_d    = 1'b0;
        tmr_load = 1'b0;
        shot_bit = coord_to_bit(sb.x_coord_code, sb.y_coord_code);
        shot_ok  = coord_valid(sb.x_coord_code, sb.y_coord_code);

        case (state_q)
            ST_IDLE: begin
                map_d   = sb.map;
                idx_d   = '0;
                ship_d  = '0;
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (map_q[idx_q] && ship_q != 4'd15) begin
                    ship_d = ship_q + 4'd1;
                end
                if (idx_q == 6'(MAP_BITS - 1)) begin
                    idx_d   = '0;
                    // An empty map is an immediate win.
                    state_d = (ship_d == 4'd0) ? ST_WON : ST_PLAY;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_PLAY: begin
                if (sb.attack_pulse) begin
                    // shot_ok is evaluated first so an out-of-range bit index never matters.
                    if (!shot_ok || hist_q[shot_bit]) begin
                        rej_d = 1'b1;
                    end else begin
                        hist_d[shot_bit] = 1'b1;
                        if (shots_q != 4'd0) begin
                            shots_d = shots_q - 4'd1;
                        end
                        rhit_d = map_q[shot_bit];
                        if (map_q[shot_bit] && hit_q != ship_q) begin
                            hit_d = hit_q + 4'd1;
                        end
                        rvalid_d = 1'b1;
                        tmr_load = 1'b1;
                        state_d  = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (tmr_done) begin
                    rvalid_d = 1'b0;
                    // Win is checked first: sinking the last ship on the last shot wins.
                    if (hit_q == ship_q) begin
                        state_d = ST_WON;
                    end else if (shots_q == 4'd0) begin
                        state_d = ST_LOST;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
            end
            default: begin
                // ST_WON / ST_LOST hold until abort.
            end
        endcase
    end

    always_comb begin
        case (state_q)
            ST_PLAY, ST_RESULT: status = GS_PLAYING;
            ST_WON:             status = GS_WON;
            ST_LOST:            status = GS_LOST;
            default:            status = GS_IDLE;
        endcase
    end

    assign sb.hit_count     = hit_q;
    assign sb.shots_left    = shots_q;
    assign sb.ship_count    = ship_q;
    assign sb.result_valid  = rvalid_q;
    assign sb.result_hit    = rhit_q;
    assign sb.shot_rejected = rej_q;
    assign sb.game_status   = status;
endmodule

// File: tb/tb_attack_scoreboard.sv
// tb_attack_scoreboard
// Two scoreboard instances (MAX_SHOTS = 15 and 3) share the attack inputs,
// each with its own enable. Expected shot outcomes are queued when a shot is
// fired and popped when the selected instance shows a result or rejection.
module tb_attack_scoreboard;
    localparam int RC = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en15, en3, atk, sel3;
    logic [2:0]  xc, yc;
    logic [34:0] mapv;

    always #5 clk = ~clk;

    attack_scoreboard_if if15 ();
    attack_scoreboard_if if3 ();

    assign if15.enable_attack = en15;
    assign if15.attack_pulse  = atk;
    assign if15.x_coord_code  = xc;
    assign if15.y_coord_code  = yc;
    assign if15.map           = mapv;
    assign if3.enable_attack  = en3;
    assign if3.attack_pulse   = atk;
    assign if3.x_coord_code   = xc;
    assign if3.y_coord_code   = yc;
    assign if3.map            = mapv;

    attack_scoreboard #(.MAX_SHOTS(15), .RESULT_CYCLES(RC), .RES_W(12)) u_dut15 (
        .clk   (clk),
        .reset (reset),
        .sb    (if15)
    );

    attack_scoreboard #(.MAX_SHOTS(3), .RESULT_CYCLES(RC), .RES_W(12)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .sb    (if3)
    );

    logic [31:0] m_hits, m_shots, m_ships, m_valid, m_hit, m_rej, m_status;
    assign m_hits   = 32'(sel3 ? if3.hit_count     : if15.hit_count);
    assign m_shots  = 32'(sel3 ? if3.shots_left    : if15.shots_left);
    assign m_ships  = 32'(sel3 ? if3.ship_count    : if15.ship_count);
    assign m_valid  = 32'(sel3 ? if3.result_valid  : if15.result_valid);
    assign m_hit    = 32'(sel3 ? if3.result_hit    : if15.result_hit);
    assign m_rej    = 32'(sel3 ? if3.shot_rejected : if15.shot_rejected);
    assign m_status = 32'(sel3 ? if3.game_status   : if15.game_status);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] is_rej;
        logic [31:0] hit;
        logic [31:0] hits;
        logic [31:0] shots;
    } exp_t;

    exp_t q[$];

    logic [31:0] prev_valid = 0;
    logic [31:0] prev_rej   = 0;
    int          run_len    = 0;
    int          last_len   = 0;
    logic [31:0] hold_done  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (m_valid == 1 && prev_valid == 0) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = q.pop_front();
                chk("result_kind", e.is_rej, 0);
                chk("result_hit", m_hit, e.hit);
                chk("hit_count", m_hits, e.hits);
                chk("shots_left", m_shots, e.shots);
            end
        end
        if (m_rej == 1) begin
            if (prev_rej == 1) begin
                chk("reject_pulse_width", 2, 1);
            end else if (q.size() == 0) begin
                chk("unexpected_reject", 1, 0);
            end else begin
                e = q.pop_front();
                chk("reject_kind", e.is_rej, 1);
                chk("reject_shots", m_shots, e.shots);
                chk("reject_hits", m_hits, e.hits);
            end
        end
        if (m_valid == 1) begin
            run_len++;
        end else if (prev_valid == 1) begin
            last_len  = run_len;
            run_len   = 0;
            hold_done = 1;
        end
        prev_valid = m_valid;
        prev_rej   = m_rej;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind: 0 = result expected, 1 = rejection expected, 2 = ignored
    task automatic fire(input int x, input int y, input int kind,
                        input int hit, input int hits, input int shots);
        exp_t e;
        @(negedge clk);
        xc  = 3'(x);
        yc  = 3'(y);
        atk = 1'b1;
        hold_done = 0;
        if (kind < 2) begin
            e.is_rej = (kind == 1) ? 32'd1 : 32'd0;
            e.hit    = hit;
            e.hits   = hits;
            e.shots  = shots;
            q.push_back(e);
        end
        @(negedge clk);
        atk = 1'b0;
    endtask

    task automatic wait_hold();
        for (int i = 0; i < RC + 100; i++) begin
            if (hold_done == 1) break;
            @(negedge clk);
            #1;
        end
        chk("hold_seen", hold_done, 1);
        chk("hold_len", last_len, RC);
    endtask

    task automatic set_map3();
        mapv     = '0;
        mapv[34] = 1'b1;
        mapv[33] = 1'b1;
        mapv[27] = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        en15  = 1'b0;
        en3   = 1'b0;
        atk   = 1'b0;
        sel3  = 1'b0;
        xc    = '0;
        yc    = '0;
        set_map3();
        cyc(3);

        chk("rst_status", m_status, 0);
        chk("rst_shots", m_shots, 15);
        chk("rst_hits", m_hits, 0);
        chk("rst_ships", m_ships, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_rej", m_rej, 0);
        sel3 = 1'b1;
        #1;
        chk("rst_shots_max3", m_shots, 3);
        sel3 = 1'b0;

        reset = 1'b0;
        cyc(1);
        en15 = 1'b1;
        cyc(35);
        chk("counting_status", m_status, 0);
        cyc(1);
        chk("play_status", m_status, 1);
        chk("ship_count", m_ships, 3);
        chk("play_shots", m_shots, 15);

        // Map changes after counting must not matter.
        mapv = '0;
        fire(0, 6, 0, 1, 1, 14);
        wait_hold();
        chk("after_hit_status", m_status, 1);

        fire(0, 6, 1, 0, 1, 14);
        fire(5, 0, 1, 0, 1, 14);
        fire(1, 7, 1, 0, 1, 14);
        cyc(2);
        chk("rej_shots_kept", m_shots, 14);
        chk("rej_hits_kept", m_hits, 1);
        chk("rej_status", m_status, 1);

        // Abort in the middle of a result hold.
        fire(4, 0, 0, 0, 1, 13);
        cyc(10);
        chk("mid_result_valid", m_valid, 1);
        en15 = 1'b0;
        cyc(1);
        chk("abort_status", m_status, 0);
        chk("abort_shots", m_shots, 15);
        chk("abort_hits", m_hits, 0);
        chk("abort_ships", m_ships, 0);
        chk("abort_valid", m_valid, 0);

        // Reset in the middle of counting.
        set_map3();
        en15 = 1'b1;
        cyc(10);
        reset = 1'b1;
        cyc(1);
        chk("cnt_rst_status", m_status, 0);
        chk("cnt_rst_ships", m_ships, 0);
        chk("cnt_rst_shots", m_shots, 15);
        chk("cnt_rst_hits", m_hits, 0);
        reset = 1'b0;
        en15  = 1'b0;
        cyc(2);

        // Three-shot game: three misses lose.
        sel3 = 1'b1;
        set_map3();
        en3 = 1'b1;
        cyc(36);
        chk("g3_ships", m_ships, 3);
        chk("g3_shots", m_shots, 3);
        chk("g3_status", m_status, 1);
        fire(4, 0, 0, 0, 0, 2);
        wait_hold();
        fire(4, 1, 0, 0, 0, 1);
        wait_hold();
        fire(4, 2, 0, 0, 0, 0);
        wait_hold();
        chk("lost_status", m_status, 3);
        fire(3, 3, 2, 0, 0, 0);
        cyc(5);
        chk("lost_frozen_status", m_status, 3);
        chk("lost_frozen_shots", m_shots, 0);
        chk("lost_frozen_valid", m_valid, 0);

        en3 = 1'b0;
        cyc(1);
        chk("g3_idle_status", m_status, 0);
        chk("g3_idle_shots", m_shots, 3);

        // Three-shot game: last ship sunk on last shot wins.
        en3 = 1'b1;
        cyc(36);
        fire(0, 6, 0, 1, 1, 2);
        wait_hold();
        fire(0, 5, 0, 1, 2, 1);
        wait_hold();
        fire(1, 6, 0, 1, 3, 0);
        wait_hold();
        chk("won_status", m_status, 2);
        fire(2, 2, 2, 0, 0, 0);
        cyc(3);
        chk("won_frozen_status", m_status, 2);
        chk("won_frozen_hits", m_hits, 3);

        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
